// File: rtl/tb_pkg.sv
// tb_pkg: shared types for the memory response model.
// Holds the queued response entry layout and the timestamp width.
package tb_pkg;

  localparam int MEM_TS_W = 16;
  localparam int MEM_MAX_DATA_W = 64;

  typedef struct packed {
    logic [MEM_MAX_DATA_W-1:0] rdata;
    logic                      err;
    logic [MEM_TS_W-1:0]       ts;
  } mem_resp_entry_t;

  // 16-bit Galois LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo: in-order response queue, power-of-two depth.
// Ports: clk_i, rst_i (sync, high), push_i/wdata_i, pop_i/rdata_o, full_o, empty_o.
module mem_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      cnt_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/mem_resp_model.sv
// mem_resp_model: behavioural memory slave with fixed-latency in-order responses.
// Ports: clk_i, rst_i (sync, high); req_i/addr_i/we_i/be_i/wdata_i -> gnt_o;
//        rvalid_o/rdata_o/err_o. Macro MEM_RESP_MODEL_STALL_EN adds LFSR grant stalls.
module mem_resp_model
  import tb_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter int          MEM_BYTES       = 'h10000,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter string       INIT_FILE       = "",
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic                gnt_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int WORDS  = MEM_BYTES / BYTES;
  localparam int IDX_W  = MEM_AW - OFF_W;

  if (DATA_W != 32 && DATA_W != 64) begin : g_chk_dw
    $error("DATA_W must be 32 or 64");
  end
  if (STALL_SEED == 16'h0) begin : g_chk_seed
    $error("STALL_SEED must be non-zero");
  end

  logic [DATA_W-1:0]   mem_q [WORDS];
  logic [IDX_W-1:0]    idx;
  logic                oob;
  logic                full;
  logic                empty;
  logic                stall;
  logic                pop;
  logic [MEM_TS_W-1:0] cyc_q;
  logic [MEM_TS_W-1:0] age;
  mem_resp_entry_t     push_e;
  mem_resp_entry_t     head_e;

  // Low address bits are dropped; anything above the array is out of range.
  assign idx = addr_i[MEM_AW-1:OFF_W];
  assign oob = |addr_i[31:MEM_AW];

`ifdef MEM_RESP_MODEL_STALL_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Full blocks grant even when the head pops this cycle.
  assign gnt_o = req_i && !full && !stall && !rst_i;

  always_ff @(posedge clk_i) begin
    if (gnt_o && we_i && !oob) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cyc_q <= '0;
    else       cyc_q <= cyc_q + 1'b1;
  end

  // Read data is the pre-edge word, so same-edge writes are not seen.
  always_comb begin
    push_e     = '0;
    push_e.err = oob;
    push_e.ts  = cyc_q;
    if (!we_i && !oob) begin
      push_e.rdata = MEM_MAX_DATA_W'(mem_q[idx]);
    end
  end

  mem_resp_fifo #(
    .WIDTH ($bits(mem_resp_entry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (gnt_o),
    .wdata_i (push_e),
    .pop_i   (pop),
    .rdata_o (head_e),
    .full_o  (full),
    .empty_o (empty)
  );

  // Modular age keeps working across counter wrap.
  assign age = cyc_q - head_e.ts;
  assign pop = !empty && (age >= MEM_TS_W'(LATENCY));

  assign rvalid_o = pop;
  assign rdata_o  = pop ? head_e.rdata[DATA_W-1:0] : '0;
  assign err_o    = pop && head_e.err;

  if (DATA_W < MEM_MAX_DATA_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^head_e.rdata[MEM_MAX_DATA_W-1:DATA_W];
  end

endmodule

// File: tb/tb_mem_resp_model.sv
// tb_mem_resp_model: directed bench with response scoreboard.
// Drives a default instance and a LATENCY=6 instance from the same stimulus.
`timescale 1ns/1ps
module tb_mem_resp_model;

  localparam int LAT_A = 2;
  localparam int LAT_B = 6;
  localparam int DEPTH = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt_a, rv_a, err_a;
  logic [31:0] rd_a;
  logic        gnt_b, rv_b, err_b;
  logic [31:0] rd_b;

  always #5 clk = ~clk;

  mem_resp_model u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(gnt_a),
    .rvalid_o(rv_a), .rdata_o(rd_a), .err_o(err_a)
  );

  mem_resp_model #(.LATENCY(LAT_B)) u_deep (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr),
    .we_i(we), .be_i(be), .wdata_i(wdata), .gnt_o(gnt_b),
    .rvalid_o(rv_b), .rdata_o(rd_b), .err_o(err_b)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] mm [int];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          prev_rst = 1'b0;
  bit          burst = 1'b0;
  bit          last_ga = 1'b0;
  int          gcnt_a = 0;
  int          gcnt_b = 0;
  logic [15:0] lfsr = SEED;
  logic        stall_m;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    if (s[0]) return (s >> 1) ^ 16'hB400;
    return s >> 1;
  endfunction

`ifdef MEM_RESP_MODEL_STALL_EN
  assign stall_m = (lfsr[1:0] == 2'b00);
`else
  assign stall_m = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_resp(input int lat);
    exp_t        e;
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    e.err = (a >= 32'h10000);
    e.data = 32'h0;
    if (!we && !e.err) e.data = mm.exists(int'(a)) ? mm[int'(a)] : 32'hx;
    e.due = cyc + lat;
    return e;
  endfunction

  task automatic score(input int w, input logic g, input logic rv,
                       input logic [31:0] rd, input logic er);
    exp_t  e;
    int    n;
    logic  eg;
    string s;
    s = (w == 0) ? "a" : "b";
    n = (w == 0) ? qa.size() : qb.size();
    if (rst) begin
      chk({s, ".gnt_in_reset"}, 32'(g), 32'h0);
      if (prev_rst) begin
        chk({s, ".rvalid_reset"}, 32'(rv), 32'h0);
        chk({s, ".rdata_reset"}, rd, 32'h0);
        chk({s, ".err_reset"}, 32'(er), 32'h0);
      end
      if (w == 0) qa.delete();
      else qb.delete();
      return;
    end
    eg = req && (n < DEPTH) && !stall_m;
    chk({s, ".gnt"}, 32'(g), 32'(eg));
    e = '{32'h0, 1'b0, -1};
    if (n > 0) begin
      if (w == 0) e = qa[0];
      else e = qb[0];
    end
    if (n > 0 && e.due == cyc) begin
      chk({s, ".rvalid"}, 32'(rv), 32'h1);
      chk({s, ".rdata"}, rd, e.data);
      chk({s, ".err"}, 32'(er), 32'(e.err));
      if (w == 0) void'(qa.pop_front());
      else void'(qb.pop_front());
    end else begin
      chk({s, ".rvalid_idle"}, 32'(rv), 32'h0);
      chk({s, ".rdata_idle"}, rd, 32'h0);
      chk({s, ".err_idle"}, 32'(er), 32'h0);
    end
    if (eg) begin
      if (w == 0) qa.push_back(model_resp(LAT_A));
      else qb.push_back(model_resp(LAT_B));
    end
  endtask

  task automatic step();
    int          k;
    logic [31:0] word;
    @(negedge clk);
    last_ga = !rst && req && (qa.size() < DEPTH) && !stall_m;
    score(0, gnt_a, rv_a, rd_a, err_a);
    score(1, gnt_b, rv_b, rd_b, err_b);
    if (last_ga && we && addr < 32'h10000) begin
      k = int'({addr[31:2], 2'b00});
      word = mm.exists(k) ? mm[k] : 32'h0;
      for (int i = 0; i < 4; i++) begin
        if (be[i]) word[8*i +: 8] = wdata[8*i +: 8];
      end
      mm[k] = word;
    end
    if (burst) begin
      gcnt_a += int'(gnt_a);
      gcnt_b += int'(gnt_b);
    end
    prev_rst = rst;
    @(posedge clk);
    cyc++;
    lfsr = rst ? SEED : lfsr_step(lfsr);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() + qb.size()) != 0 && t < 40) begin
      step();
      t++;
    end
    chk("drain", 32'(qa.size() + qb.size()), 32'h0);
  endtask

  task automatic op(input logic w, input logic [31:0] a,
                    input logic [3:0] b, input logic [31:0] d);
    int t;
    drain();
    req = 1'b1;
    we = w;
    addr = a;
    be = b;
    wdata = d;
    t = 0;
    do begin
      step();
      t++;
    end while (!last_ga && t < 20);
    chk("grant_wait", 32'(last_ga), 32'h1);
    req = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    be = '0;
    wdata = '0;
    #1;
    step();
    req = 1'b1;
    addr = 32'h100;
    step();
    rst = 1'b0;
    req = 1'b0;
    step();
    step();

    op(1'b1, 32'h100, 4'hF, 32'hA5A5A5A5);
    op(1'b0, 32'h100, 4'h0, 32'h0);
    op(1'b1, 32'h200, 4'hF, 32'h11223344);
    op(1'b1, 32'h200, 4'b0001, 32'h000000FF);
    op(1'b0, 32'h200, 4'h0, 32'h0);
    op(1'b1, 32'h000, 4'hF, 32'h12345678);
    op(1'b1, 32'h10000, 4'hF, 32'hDEADBEEF);
    op(1'b0, 32'h10000, 4'h0, 32'h0);
    op(1'b0, 32'h000, 4'h0, 32'h0);
    op(1'b0, 32'h102, 4'h0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      op(1'b1, 32'h300 + 32'(4*i), 4'hF, $urandom);
    end
    drain();

    burst = 1'b1;
    req = 1'b1;
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h300 + 32'(4*i);
      step();
    end
    burst = 1'b0;
    req = 1'b0;
`ifndef MEM_RESP_MODEL_STALL_EN
    chk("burst_grants_a", 32'(gcnt_a), 32'd8);
    chk("burst_grants_b", 32'(gcnt_b), 32'd5);
`endif
    drain();

    req = 1'b1;
    addr = 32'h100;
    for (int i = 0; i < 3; i++) step();
    req = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    op(1'b0, 32'h100, 4'h0, 32'h0);
    drain();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
